// File: rtl/gtp_drp_pkg.sv
// Shared types and widths for the GTPE2 DRP arbiters.
// Also used by the GTPE2_CHANNEL DRP arbiter.
package gtp_drp_pkg;

    localparam int DRP_ADDR_W = 8;
    localparam int DRP_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } drp_state_t;

    // An index register of width 0 is not legal, so one requester still gets 1 bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gtp_common_drp_arbiter_if.sv
// Requester and GTPE2_COMMON DRP bus bundle for the DRP arbiter.
// The slave side is the arbiter; the master side is the requesters plus the DRP tile.
interface gtp_common_drp_arbiter_if
    import gtp_drp_pkg::*;
#(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_we;
    logic [DRP_ADDR_W*N_REQ-1:0] req_addr;
    logic [DRP_DATA_W*N_REQ-1:0] req_di;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            rsp_valid;
    logic [DRP_DATA_W-1:0]       rsp_data;
    logic                        rsp_err;
    logic                        drp_en;
    logic                        drp_we;
    logic [DRP_ADDR_W-1:0]       drp_addr;
    logic [DRP_DATA_W-1:0]       drp_di;
    logic [DRP_DATA_W-1:0]       drp_do;
    logic                        drp_rdy;

    modport slave (
        input  req_valid, req_we, req_addr, req_di, drp_do, drp_rdy,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               drp_en, drp_we, drp_addr, drp_di
    );

    modport master (
        output req_valid, req_we, req_addr, req_di, drp_do, drp_rdy,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               drp_en, drp_we, drp_addr, drp_di
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1,
// wrapping modulo N_REQ (not a power of two).
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             any_o
);

    int idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr_i) + i) % N_REQ;
            if (!any_o && req_i[idx]) begin
                any_o       = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/gtp_common_drp_arbiter.sv
// Round-robin arbiter sharing the single GTPE2_COMMON DRP port between N_REQ requesters,
// one outstanding transaction at a time, with a DRPRDY timeout.
//
// state | meaning
// IDLE  | no transaction; arbitrate among req_valid
// ISSUE | drp_en/drp_we asserted for this one cycle
// WAIT  | waiting for drp_rdy, timer counting toward TIMEOUT-1
module gtp_common_drp_arbiter
    import gtp_drp_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    gtp_common_drp_arbiter_if.slave bus,
    output logic                    busy,
    output logic                    spurious_rdy
);

    localparam int PTR_W = ptr_width(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    drp_state_t            state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [N_REQ-1:0]      req_ready_q, req_ready_d;
    logic [N_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DRP_DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  drp_en_q, drp_en_d;
    logic                  drp_we_q, drp_we_d;
    logic [DRP_ADDR_W-1:0] drp_addr_q, drp_addr_d;
    logic [DRP_DATA_W-1:0] drp_di_q, drp_di_d;
    logic                  busy_q, busy_d;
    logic                  spurious_q, spurious_d;

    logic [N_REQ-1:0]      grant;
    logic [PTR_W-1:0]      grant_idx;
    logic                  any_req;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req_i       (bus.req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (any_req)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        drp_en_d    = 1'b0;
        drp_we_d    = 1'b0;
        drp_addr_d  = drp_addr_q;
        drp_di_d    = drp_di_q;
        // Ready from the tile is only meaningful while a transaction is waiting on it.
        spurious_d  = spurious_q | (bus.drp_rdy && (state_q != WAIT));

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = ISSUE;
                    ptr_d       = grant_idx;
                    req_ready_d = grant;
                    drp_en_d    = 1'b1;
                    drp_we_d    = bus.req_we[grant_idx];
                    drp_addr_d  = bus.req_addr[int'(grant_idx)*DRP_ADDR_W +: DRP_ADDR_W];
                    drp_di_d    = bus.req_di[int'(grant_idx)*DRP_DATA_W +: DRP_DATA_W];
                end
            end
            ISSUE: begin
                state_d = WAIT;
                timer_d = '0;
            end
            WAIT: begin
                // A ready arriving on the timeout cycle still counts as success.
                if (bus.drp_rdy) begin
                    state_d            = IDLE;
                    rsp_valid_d[ptr_q] = 1'b1;
                    rsp_data_d         = bus.drp_do;
                    rsp_err_d          = 1'b0;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d            = IDLE;
                    rsp_valid_d[ptr_q] = 1'b1;
                    rsp_data_d         = '0;
                    rsp_err_d          = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_W'(N_REQ - 1);
            timer_q     <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            drp_en_q    <= 1'b0;
            drp_we_q    <= 1'b0;
            drp_addr_q  <= '0;
            drp_di_q    <= '0;
            busy_q      <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            drp_en_q    <= drp_en_d;
            drp_we_q    <= drp_we_d;
            drp_addr_q  <= drp_addr_d;
            drp_di_q    <= drp_di_d;
            busy_q      <= busy_d;
            spurious_q  <= spurious_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.drp_en    = drp_en_q;
    assign bus.drp_we    = drp_we_q;
    assign bus.drp_addr  = drp_addr_q;
    assign bus.drp_di    = drp_di_q;
    assign busy          = busy_q;
    assign spurious_rdy  = spurious_q;

endmodule

// File: tb/tb_gtp_common_drp_arbiter.sv
// Directed bench for gtp_common_drp_arbiter with a small DRP tile model
// returning drp_rdy a programmable number of cycles after drp_en.
module tb_gtp_common_drp_arbiter;

    localparam int N_REQ   = 2;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        spurious_rdy;
    logic        model_rdy;
    logic        spur_rdy;
    logic [15:0] model_do;
    int          model_lat;
    int          model_cnt;

    int errors    = 0;
    int checks    = 0;
    int proto_err = 0;
    int en_seen;
    int rdy_seen;
    int ncyc;

    logic [N_REQ-1:0] vprev;

    gtp_common_drp_arbiter_if #(.N_REQ(N_REQ)) bus ();

    gtp_common_drp_arbiter #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .spurious_rdy (spurious_rdy)
    );

    assign bus.drp_rdy = model_rdy | spur_rdy;
    assign bus.drp_do  = model_do;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // DRP tile model: drp_rdy exactly model_lat cycles after drp_en; 0 means never.
    initial begin
        model_rdy = 1'b0;
        model_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            model_rdy = 1'b0;
            if (model_cnt > 0) begin
                model_cnt--;
                if (model_cnt == 0) model_rdy = 1'b1;
            end
            if (bus.drp_en && model_lat > 0) model_cnt = model_lat;
        end
    end

    // Requesters must hold req_valid until their req_ready pulse.
    always @(posedge clk) begin
        if (rst) begin
            vprev <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                assert (!(vprev[i] && !bus.req_valid[i] && !bus.req_ready[i])) else begin
                    proto_err <= proto_err + 1;
                    $error("FAIL protocol_req%0d: req_valid observed=0 required=1 until req_ready", i);
                end
            end
            vprev <= bus.req_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input int budget, output int n);
        n        = 0;
        en_seen  = 0;
        rdy_seen = 0;
        do begin
            tick();
            n++;
            if (bus.drp_en) en_seen++;
            if (bus.req_ready != '0) rdy_seen++;
        end while (bus.rsp_valid == '0 && n < budget);
    endtask

    task automatic wait_en(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.drp_en && n < budget);
        chk("wait_en_seen", bus.drp_en, 1);
    endtask

    initial begin
        rst           = 1'b1;
        spur_rdy      = 1'b0;
        model_lat     = 0;
        model_do      = '0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_di    = '0;
        repeat (3) tick();

        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_drp_en", bus.drp_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spurious", spurious_rdy, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_drp_addr", bus.drp_addr, 0);
        rst = 1'b0;
        tick();

        // Single write, rdy 3 cycles after drp_en; writes still return drp_do
        model_lat     = 3;
        model_do      = 16'h5A5A;
        bus.req_valid = 2'b01;
        bus.req_we    = 2'b01;
        bus.req_addr  = 16'h0004;
        bus.req_di    = 32'h0000_1234;
        tick();
        chk("wr_req_ready", bus.req_ready, 2'b01);
        chk("wr_drp_en", bus.drp_en, 1);
        chk("wr_drp_we", bus.drp_we, 1);
        chk("wr_drp_addr", bus.drp_addr, 8'h04);
        chk("wr_drp_di", bus.drp_di, 16'h1234);
        chk("wr_busy", busy, 1);
        bus.req_valid = 2'b00;
        wait_rsp(20, ncyc);
        chk("wr_latency", ncyc, 4);
        chk("wr_rsp_valid", bus.rsp_valid, 2'b01);
        chk("wr_rsp_err", bus.rsp_err, 0);
        chk("wr_rsp_data", bus.rsp_data, 16'h5A5A);
        chk("wr_busy_done", busy, 0);
        chk("wr_single_en", en_seen, 0);
        chk("wr_single_ready", rdy_seen, 0);
        chk("wr_addr_held", bus.drp_addr, 8'h04);

        // Read from requester 1
        model_lat     = 2;
        model_do      = 16'hBEEF;
        bus.req_valid = 2'b10;
        bus.req_we    = 2'b00;
        bus.req_addr  = 16'h2A00;
        bus.req_di    = 32'h0;
        tick();
        chk("rd_req_ready", bus.req_ready, 2'b10);
        chk("rd_drp_en", bus.drp_en, 1);
        chk("rd_drp_we", bus.drp_we, 0);
        chk("rd_drp_addr", bus.drp_addr, 8'h2A);
        bus.req_valid = 2'b00;
        wait_rsp(20, ncyc);
        chk("rd_latency", ncyc, 3);
        chk("rd_rsp_valid", bus.rsp_valid, 2'b10);
        chk("rd_rsp_data", bus.rsp_data, 16'hBEEF);
        chk("rd_rsp_err", bus.rsp_err, 0);
        chk("rd_single_en", en_seen, 0);
        chk("rd_single_ready", rdy_seen, 0);
        tick();
        chk("rd_rsp_pulse", bus.rsp_valid, 0);
        chk("rd_data_hold", bus.rsp_data, 16'hBEEF);

        // Contention from reset: both held, grants alternate 0,1,0,1
        rst = 1'b1;
        repeat (2) tick();
        rst           = 1'b0;
        model_lat     = 1;
        model_do      = 16'h1111;
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b00;
        bus.req_addr  = 16'h2010;
        for (int t = 0; t < 4; t++) begin
            wait_en(20, ncyc);
            chk("cont_grant", bus.req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk("cont_addr", bus.drp_addr, (t % 2 == 0) ? 8'h10 : 8'h20);
            if (t > 0) chk("cont_spacing", ncyc, 1);
            wait_rsp(20, ncyc);
            chk("cont_rsp", bus.rsp_valid, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk("cont_rsp_lat", ncyc, 2);
            chk("cont_no_overlap", en_seen, 0);
        end
        wait_en(20, ncyc);
        chk("cont_grant5", bus.req_ready, 2'b01);
        bus.req_valid = 2'b10;
        wait_rsp(20, ncyc);
        wait_en(20, ncyc);
        chk("cont_grant6", bus.req_ready, 2'b10);
        bus.req_valid = 2'b00;
        wait_rsp(20, ncyc);
        chk("cont_rsp6", bus.rsp_valid, 2'b10);

        // Timeout: tile never answers
        model_lat     = 0;
        bus.req_valid = 2'b01;
        bus.req_addr  = 16'h0033;
        tick();
        chk("to_drp_en", bus.drp_en, 1);
        chk("to_req_ready", bus.req_ready, 2'b01);
        bus.req_valid = 2'b00;
        wait_rsp(100, ncyc);
        chk("to_latency", ncyc, 65);
        chk("to_rsp_valid", bus.rsp_valid, 2'b01);
        chk("to_rsp_err", bus.rsp_err, 1);
        chk("to_rsp_data", bus.rsp_data, 0);
        chk("to_busy", busy, 0);
        tick();
        chk("to_rsp_pulse", bus.rsp_valid, 0);
        chk("to_err_hold", bus.rsp_err, 1);

        // Reset two cycles after drp_en, while waiting
        model_lat     = 5;
        bus.req_valid = 2'b10;
        bus.req_addr  = 16'h7700;
        bus.req_di    = 32'hBBBB_0000;
        tick();
        chk("rw_drp_en", bus.drp_en, 1);
        chk("rw_req_ready", bus.req_ready, 2'b10);
        bus.req_valid = 2'b00;
        tick();
        tick();
        chk("rw_busy_wait", busy, 1);
        rst = 1'b1;
        tick();
        chk("rw_rsp_valid", bus.rsp_valid, 0);
        chk("rw_drp_en_off", bus.drp_en, 0);
        chk("rw_busy", busy, 0);
        chk("rw_drp_addr", bus.drp_addr, 0);
        chk("rw_drp_di", bus.drp_di, 0);
        chk("rw_rsp_err", bus.rsp_err, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_no_rsp", bus.rsp_valid, 0);
        end
        rst           = 1'b0;
        model_lat     = 1;
        bus.req_valid = 2'b11;
        tick();
        chk("rw_first_grant", bus.req_ready, 2'b01);
        bus.req_valid = 2'b10;
        wait_rsp(20, ncyc);
        chk("rw_rsp0", bus.rsp_valid, 2'b01);
        wait_en(20, ncyc);
        chk("rw_second_grant", bus.req_ready, 2'b10);
        bus.req_valid = 2'b00;
        wait_rsp(20, ncyc);
        chk("rw_rsp1", bus.rsp_valid, 2'b10);
        chk("rw_no_spurious", spurious_rdy, 0);

        // Spurious rdy in IDLE, sticky across a normal transaction until reset
        spur_rdy = 1'b1;
        tick();
        spur_rdy = 1'b0;
        chk("sp_set", spurious_rdy, 1);
        chk("sp_no_rsp", bus.rsp_valid, 0);
        model_lat     = 2;
        model_do      = 16'hC0DE;
        bus.req_valid = 2'b01;
        bus.req_we    = 2'b01;
        bus.req_addr  = 16'h0055;
        bus.req_di    = 32'h0000_AAAA;
        tick();
        chk("sp_drp_di", bus.drp_di, 16'hAAAA);
        bus.req_valid = 2'b00;
        wait_rsp(20, ncyc);
        chk("sp_rsp_valid", bus.rsp_valid, 2'b01);
        chk("sp_rsp_data", bus.rsp_data, 16'hC0DE);
        chk("sp_sticky", spurious_rdy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("sp_cleared", spurious_rdy, 0);

        errors += proto_err;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gtp_common_drp_arbiter.md
Name: gtp_common_drp_arbiter

Overview:
- Shares the single DRP port of a GTPE2_COMMON tile between N independent requesters, e.g. a PLL0/PLL1 reconfiguration sequencer and a debug bridge.
- Sits between the requesters and the GTPE2_COMMON DRP pins (DRPEN, DRPWE, DRPADDR, DRPDI, DRPDO, DRPRDY).
- Grants requesters round-robin and guarantees one outstanding DRP transaction at a time.
- Reports a timeout if DRPRDY never returns.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- TIMEOUT, 64, cycles spent in WAIT without DRPRDY before the transaction is aborted (>=2).

Ports:
- clk  in  1  DRP clock; also drives GTPE2_COMMON DRPCLK.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request; held until the matching req_ready pulse.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  8*N_REQ  DRP address; requester i uses bits [8i+7:8i].
- req_di  in  16*N_REQ  write data; requester i uses bits [16i+15:16i].
- req_ready  out  N_REQ  one-cycle accept pulse, one-hot.
- rsp_valid  out  N_REQ  one-cycle completion pulse, one-hot.
- rsp_data  out  16  read data, valid with rsp_valid; shared by all requesters.
- rsp_err  out  1  1 = timeout, valid with rsp_valid.
- drp_en  out  1  to DRPEN.
- drp_we  out  1  to DRPWE.
- drp_addr  out  8  to DRPADDR.
- drp_di  out  16  to DRPDI.
- drp_do  in  16  from DRPDO.
- drp_rdy  in  1  from DRPRDY.
- busy  out  1  high whenever state != IDLE.
- spurious_rdy  out  1  sticky; set by drp_rdy outside WAIT, cleared only by rst.

Behaviour:
- Reset: all outputs are registered and 0; state = IDLE; round-robin pointer = N_REQ-1, so requester 0 has first priority; timer = 0.
- rst mid-transaction: state returns to IDLE and drp_en drops. No rsp_valid is issued for the dropped transaction.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from pointer+1, with modulo wrap.
  - Latch we/addr/di for the winner and move the pointer to the winner.
  - Next cycle: state = ISSUE, req_ready[winner] = 1.
  - If no req_valid is high, stay in IDLE.
- ISSUE:
  - drp_en = 1 and drp_we = latched we, for exactly one cycle.
  - drp_addr/drp_di are driven with the latched values and held stable until the next ISSUE.
  - Go to WAIT and clear the timer.
- WAIT:
  - drp_rdy sampled high: next cycle rsp_valid[winner] = 1, rsp_data = drp_do (writes also return drp_do), rsp_err = 0, state = IDLE.
  - Otherwise the timer increments. When the timer reaches TIMEOUT-1 without drp_rdy: next cycle rsp_valid[winner] = 1, rsp_err = 1, rsp_data = 0, state = IDLE.
  - drp_rdy arriving in the same cycle as the timeout is treated as success.
- Latency:
  - req_valid seen in IDLE at cycle t: req_ready and drp_en at t+1.
  - drp_rdy at cycle t+1+k (k>=1): rsp_valid at t+2+k.
  - The arbiter re-arbitrates in the rsp_valid cycle, so the minimum spacing between drp_en pulses is k+2 cycles.
- rsp_data and rsp_err hold their values until the next rsp_valid.
- drp_rdy in IDLE or ISSUE is ignored for transaction purposes and sets spurious_rdy.
- A requester deasserting req_valid before req_ready is a protocol violation; behaviour is undefined, and the bench asserts against it.
- Widths: timer width = clog2(TIMEOUT). Pointer width = clog2(N_REQ), minimum 1 bit. Pointer wrap uses N_REQ, not a power of 2.

Decomposition:
- Shared package gtp_drp_pkg:
  - DRP_ADDR_W = 8, DRP_DATA_W = 16.
  - drp_state_t enum {IDLE, ISSUE, WAIT}.
- Sub-module rr_arbiter: combinational round-robin picker.
  - Inputs: req[N_REQ], ptr.
  - Outputs: grant one-hot, grant_idx, any.
  - Reused later by the GTPE2_CHANNEL DRP arbiter.

Test Plan:
- Single write: req0 we=1 addr=8'h04 di=16'h1234, DRP model rdy 3 cycles after drp_en -> one drp_en pulse with addr=04/di=1234/we=1; req_ready[0] in the same cycle; rsp_valid[0] 1 cycle after rdy with rsp_err=0.
- Read: req1 we=0 addr=8'h2A, model returns drp_do=16'hBEEF -> rsp_valid[1], rsp_data=BEEF; req_ready and rsp_valid each pulse exactly once.
- Contention: req0 and req1 held continuously for 4 transactions from reset -> grant order 0,1,0,1; never two drp_en pulses without an intervening rsp_valid.
- Timeout: TIMEOUT=64, model never asserts rdy -> rsp_valid[0] with rsp_err=1 and rsp_data=0, exactly 65 cycles after drp_en; busy drops in the same cycle.
- Reset mid-WAIT: rst asserted 2 cycles after drp_en -> next cycle all outputs 0, no rsp_valid; the next request is granted to requester 0.
- Spurious rdy: drp_rdy pulsed while in IDLE -> spurious_rdy = 1 and stays 1 through subsequent normal transactions until rst.
